// File: rtl/note_sequencer.sv
// Purpose: plays up to 16 stored note codes as a square wave, advancing on step ticks.
// Latency: start/step take effect on the next clock edge; buzzer toggles every HP cycles.
// Backpressure: none; writes are accepted every cycle, and step ticks in IDLE or DONE are dropped.
// Ports: clock/reset (sync, active-high); reset_current_index = start/restart; step = tick;
//        seq_length = notes to play; note_wr_* = note memory write port;
//        current_index/note_code = playing note; buzzer = piezo drive; busy/done = status.
module note_sequencer #(
  parameter int TONE_BASE  = 4000,
  parameter int NOTE_STEPS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset_current_index,
  input  logic       step,
  input  logic [3:0] seq_length,
  input  logic       note_wr_en,
  input  logic [3:0] note_wr_addr,
  input  logic [2:0] note_wr_data,
  output logic [3:0] current_index,
  output logic [2:0] note_code,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  localparam int SW = (NOTE_STEPS < 2) ? 1 : $clog2(NOTE_STEPS + 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      code_q, code_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [15:0]     tone_q, tone_d;
  logic            buzzer_q, buzzer_d;
  logic [2:0]      mem_q [16];
  logic [2:0]      mem_d [16];

  logic [SW-1:0]   step_nxt;
  logic [3:0]      idx_inc;
  logic [15:0]     half_period;
  logic [15:0]     hp_m1;

  // Higher codes sound higher: the half-period shrinks as the code grows.
  assign half_period = 16'(TONE_BASE) * {12'd0, 4'd8 - {1'b0, code_q}};
  assign hp_m1       = half_period - 16'd1;
  assign step_nxt    = step_cnt_q + SW'(1);
  assign idx_inc     = idx_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    step_cnt_d = step_cnt_q;
    tone_d     = '0;
    buzzer_d   = 1'b0;
    mem_d      = mem_q;

    if (note_wr_en) begin
      mem_d[note_wr_addr] = note_wr_data;
    end

    // Tone generator; a rest keeps the buzzer low but the step timing is unchanged.
    if (state_q == PLAY && code_q != 3'd0) begin
      if (tone_q == hp_m1) begin
        tone_d   = '0;
        buzzer_d = ~buzzer_q;
      end else begin
        tone_d   = tone_q + 16'd1;
        buzzer_d = buzzer_q;
      end
    end

    // A restart request outranks any step tick arriving in the same cycle.
    if (reset_current_index) begin
      if (seq_length != 4'd0) begin
        state_d    = PLAY;
        idx_d      = 4'd0;
        code_d     = mem_q[0];
        step_cnt_d = '0;
        tone_d     = '0;
        buzzer_d   = 1'b0;
      end else if (state_q != IDLE) begin
        state_d    = IDLE;
        step_cnt_d = '0;
      end
    end else begin
      case (state_q)
        PLAY: begin
          if (step) begin
            if (step_nxt == SW'(NOTE_STEPS)) begin
              state_d    = GAP;
              step_cnt_d = '0;
            end else begin
              step_cnt_d = step_nxt;
            end
          end
        end
        GAP: begin
          if (step) begin
            // ">=" so that shrinking seq_length mid-sequence still terminates.
            if ({1'b0, idx_q} + 5'd1 >= {1'b0, seq_length}) begin
              state_d = DONE;
            end else begin
              state_d  = PLAY;
              idx_d    = idx_inc;
              code_d   = mem_q[idx_inc];
              tone_d   = '0;
              buzzer_d = 1'b0;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end

    // Silence outside PLAY, including the cycle we leave it.
    if (state_d != PLAY) begin
      tone_d   = '0;
      buzzer_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      code_q     <= 3'd0;
      step_cnt_q <= '0;
      tone_q     <= '0;
      buzzer_q   <= 1'b0;
      mem_q      <= '{default: 3'd0};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      step_cnt_q <= step_cnt_d;
      tone_q     <= tone_d;
      buzzer_q   <= buzzer_d;
      mem_q      <= mem_d;
    end
  end

  assign current_index = idx_q;
  assign note_code     = code_q;
  assign buzzer        = buzzer_q;
  assign busy          = (state_q == PLAY) || (state_q == GAP);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reset_current_index = 1'b0;
  logic       step = 1'b0;
  logic [3:0] seq_length = 4'd0;
  logic       note_wr_en = 1'b0;
  logic [3:0] note_wr_addr = 4'd0;
  logic [2:0] note_wr_data = 3'd0;
  logic [3:0] current_index;
  logic [2:0] note_code;
  logic       buzzer;
  logic       busy;
  logic       done;

  note_sequencer #(.TONE_BASE(4), .NOTE_STEPS(2)) dut (
    .clock               (clock),
    .reset               (reset),
    .reset_current_index (reset_current_index),
    .step                (step),
    .seq_length          (seq_length),
    .note_wr_en          (note_wr_en),
    .note_wr_addr        (note_wr_addr),
    .note_wr_data        (note_wr_data),
    .current_index       (current_index),
    .note_code           (note_code),
    .buzzer              (buzzer),
    .busy                (busy),
    .done                (done)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // One record per change of {current_index, note_code, busy, done}.
  // at = cycle the change must appear (-1 = any); period = buzzer period
  // expected while this record holds (0 = no repeating tone).
  typedef struct {
    int         at;
    logic [3:0] idx;
    logic [2:0] code;
    logic       busy;
    logic       done;
    int         period;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic expect_ev(input int at, input logic [3:0] idx, input logic [2:0] code,
                           input logic bsy, input logic dn, input int period);
    exp_t e;
    e.at = at; e.idx = idx; e.code = code; e.busy = bsy; e.done = dn; e.period = period;
    exp_q.push_back(e);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    reset_current_index = 1'b1;
    cyc_wait(1);
    reset_current_index = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc_wait(1);
    step = 1'b0;
  endtask

  // n steps spaced 100 cycles apart
  task automatic steps(input int n);
    repeat (n) begin
      pulse_step();
      cyc_wait(99);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [2:0] data);
    note_wr_en   = 1'b1;
    note_wr_addr = addr;
    note_wr_data = data;
    cyc_wait(1);
    note_wr_en   = 1'b0;
  endtask

  // Monitor: on every output change pop the next expectation and compare;
  // also measure the buzzer period held during the previous record.
  initial begin : monitor
    logic [9:0] cur_t;
    logic [9:0] last_t;
    bit         first;
    bit         buz_prev;
    int         last_rise;
    int         per;
    int         exp_per;
    int         iv;
    exp_t       e;
    first = 1'b1; buz_prev = 1'b0; last_rise = -1; per = 0; exp_per = 0; last_t = '0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        cur_t = {current_index, note_code, busy, done, 1'b0};
        if (buzzer && !buz_prev) begin
          if (last_rise >= 0) begin
            iv = cyc - last_rise;
            if (per == 0) per = iv;
            else if (iv != per) per = -1;
          end
          last_rise = cyc;
        end
        buz_prev = buzzer;
        if (first || cur_t != last_t) begin
          if (!first) begin
            checks++;
            if (per != exp_per) begin
              errors++;
              $display("FAIL buzzer_period before cyc %0d: got %0d required %0d", cyc, per, exp_per);
            end
          end
          first = 1'b0; last_t = cur_t; per = 0; last_rise = -1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            exp_per = 0;
            $display("FAIL unexpected_event cyc %0d: got idx=%0d code=%0d busy=%0d done=%0d, required no change",
                     cyc, current_index, note_code, busy, done);
          end else begin
            e = exp_q.pop_front();
            exp_per = e.period;
            if (current_index !== e.idx || note_code !== e.code || busy !== e.busy ||
                done !== e.done || buzzer !== 1'b0 || (e.at >= 0 && cyc != e.at)) begin
              errors++;
              $display("FAIL event: got idx=%0d code=%0d busy=%0d done=%0d buz=%0d cyc=%0d required idx=%0d code=%0d busy=%0d done=%0d buz=0 cyc=%0d",
                       current_index, note_code, busy, done, buzzer, cyc,
                       e.idx, e.code, e.busy, e.done, e.at);
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    cyc_wait(2);
    expect_ev(-1, 4'd0, 3'd0, 1'b0, 1'b0, 0);
    mon_en = 1'b1;
    cyc_wait(1);
    reset = 1'b0;
    cyc_wait(2);

    // Three-note sequence {7,0,1}
    wr(4'd0, 3'd7);
    wr(4'd1, 3'd0);
    wr(4'd2, 3'd1);
    seq_length = 4'd3;
    expect_ev(cyc + 1, 4'd0, 3'd7, 1'b1, 1'b0, 8);
    pulse_start();
    cyc_wait(99);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd0, 1'b1, 1'b0, 0);
    steps(3);
    expect_ev(cyc + 1, 4'd2, 3'd1, 1'b1, 1'b0, 56);
    steps(3);
    expect_ev(cyc + 1, 4'd2, 3'd1, 1'b0, 1'b1, 0);
    expect_ev(cyc + 2, 4'd2, 3'd1, 1'b0, 1'b0, 0);
    steps(1);

    // Steps in IDLE, then a start with seq_length=0: no output change
    steps(3);
    seq_length = 4'd0;
    pulse_start();
    cyc_wait(20);

    // Rewrite of the playing address holds until it is next latched
    wr(4'd1, 3'd5);
    seq_length = 4'd3;
    expect_ev(cyc + 1, 4'd0, 3'd7, 1'b1, 1'b0, 8);
    pulse_start();
    cyc_wait(99);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd5, 1'b1, 1'b0, 24);
    pulse_step();
    cyc_wait(30);
    wr(4'd1, 3'd3);
    cyc_wait(68);
    pulse_step();
    cyc_wait(50);
    expect_ev(cyc + 1, 4'd0, 3'd7, 1'b1, 1'b0, 8);
    pulse_start();
    cyc_wait(99);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd3, 1'b1, 1'b0, 40);
    steps(3);
    expect_ev(cyc + 1, 4'd2, 3'd1, 1'b1, 1'b0, 56);
    steps(1);

    // Restart at index 2 with a simultaneous step; step counter must clear
    pulse_step();
    cyc_wait(49);
    expect_ev(cyc + 1, 4'd0, 3'd7, 1'b1, 1'b0, 8);
    reset_current_index = 1'b1;
    step = 1'b1;
    cyc_wait(1);
    reset_current_index = 1'b0;
    step = 1'b0;
    cyc_wait(99);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd3, 1'b1, 1'b0, 40);
    pulse_step();

    // Reset mid-PLAY while the buzzer is high
    cyc_wait(105);
    expect_ev(cyc + 1, 4'd0, 3'd0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    cyc_wait(1);
    reset = 1'b0;
    cyc_wait(5);

    // Memory is cleared: every note is now a rest; shrink seq_length mid-sequence
    expect_ev(cyc + 1, 4'd0, 3'd0, 1'b1, 1'b0, 0);
    pulse_start();
    cyc_wait(99);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd0, 1'b1, 1'b0, 0);
    pulse_step();
    cyc_wait(10);
    seq_length = 4'd1;
    cyc_wait(89);
    steps(2);
    expect_ev(cyc + 1, 4'd1, 3'd0, 1'b0, 1'b1, 0);
    expect_ev(cyc + 2, 4'd1, 3'd0, 1'b0, 1'b0, 0);
    pulse_step();
    cyc_wait(20);

    // Restart with seq_length=0 while playing returns to IDLE
    seq_length = 4'd3;
    expect_ev(cyc + 1, 4'd0, 3'd0, 1'b1, 1'b0, 0);
    pulse_start();
    cyc_wait(10);
    seq_length = 4'd0;
    expect_ev(cyc + 1, 4'd0, 3'd0, 1'b0, 1'b0, 0);
    pulse_start();
    cyc_wait(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TONE_BASE, default 4000: base half-period in clock cycles; legal range 1..9362.
REQ-002 Parameter NOTE_STEPS, default 3: step pulses each note sounds before its gap.
REQ-003 clock  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 reset_current_index  in  1  one-cycle start/restart request from play_music.
REQ-006 step  in  1  one-cycle timing tick (the play_music click).
REQ-007 seq_length  in  4  number of notes to play; 0 means nothing to play.
REQ-008 note_wr_en  in  1  note memory write strobe.
REQ-009 note_wr_addr  in  4  note memory write address.
REQ-010 note_wr_data  in  3  note code: 0 = rest, 1..7 = tone.
REQ-011 current_index  out  4  address of the note being played.
REQ-012 note_code  out  3  latched code of the current note.
REQ-013 buzzer  out  1  square-wave drive to the piezo.
REQ-014 busy  out  1  high in PLAY and GAP.
REQ-015 done  out  1  one-cycle pulse at the end of the sequence.

Function
REQ-016 Note memory SHALL be 16 x 3 bits with a synchronous write on note_wr_en, accepted in every state.
REQ-017 The state machine SHALL have four states: IDLE, PLAY, GAP, DONE.
REQ-018 IDLE: reset_current_index=1 with seq_length!=0 SHALL move to PLAY next cycle, set current_index=0 and latch note_code=mem[0].
REQ-019 IDLE: reset_current_index=1 with seq_length=0 SHALL be ignored; step SHALL be ignored.
REQ-020 PLAY: each step pulse SHALL increment a step counter; the step that brings it to NOTE_STEPS SHALL move to GAP and clear the counter.
REQ-021 GAP: buzzer SHALL be 0; the next step SHALL either go to DONE (if current_index==seq_length-1) or increment current_index, latch note_code=mem[new index] and re-enter PLAY.
REQ-022 DONE: done SHALL be 1 for exactly one cycle, then the block returns to IDLE; current_index and note_code SHALL hold their values.
REQ-023 Tone: in PLAY with note_code!=0, a 16-bit counter SHALL count 0..HP-1 with HP=TONE_BASE*(8-note_code), toggle buzzer when it reaches HP-1, and wrap to 0.
REQ-024 note_code=0 (rest) SHALL hold buzzer at 0 with the same step timing as a tone.
REQ-025 On every entry into PLAY the tone counter and buzzer SHALL be cleared to 0.
REQ-026 reset_current_index=1 in PLAY, GAP or DONE SHALL restart exactly as in REQ-018 (seq_length!=0) or go to IDLE (seq_length=0); it wins over a simultaneous step.
REQ-027 A write to the address currently playing SHALL NOT change note_code until that address is next latched.
REQ-028 seq_length is sampled continuously; lowering it below current_index+1 SHALL end the sequence at the next GAP step.

Reset
REQ-029 reset SHALL clear all state synchronously: state=IDLE, current_index=0, note_code=0, buzzer=0, busy=0, done=0, counters=0, note memory all 0.
REQ-030 reset SHALL override every other input in the same cycle, including mid-sequence.

Verification (TONE_BASE=4, NOTE_STEPS=2)
REQ-031 Write mem[0..2]={7,0,1}, seq_length=3, pulse start, step every 100 cycles -> buzzer period 8 cycles on note 0, 0 on note 1, 56 cycles on note 2; done pulses once after the 9th step; busy falls the same cycle.
REQ-032 seq_length=0, pulse start -> busy stays 0 and done never asserts.
REQ-033 Restart at index 2 of 3 with step asserted in the same cycle -> current_index=0, step counter=0, PLAY re-entered.
REQ-034 Assert reset mid-PLAY with buzzer=1 -> next cycle all outputs are 0 and memory reads back 0.
REQ-035 Write mem[1]=3 while index 1 plays code 5 -> tone stays at HP=12 until the next restart, then HP=20.
REQ-036 Step pulses in IDLE -> current_index, busy and buzzer unchanged.
